// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver with optional parity, delivering words on a valid/ready handshake
//   clk        system clock
//   arst_n     asynchronous active-low reset
//   s_tick     one-cycle oversampling strobe (OS per bit)
//   rx         asynchronous serial input, idle high
//   rx_data    last received word (DBIT bits, LSB received first)
//   rx_valid   rx_data holds an unconsumed word
//   rx_ready   consumer accepts the word when rx_valid & rx_ready
//   frame_err  stop bit of the word in rx_data sampled low
//   parity_err parity mismatch for the word in rx_data
//   overrun    one-cycle pulse when an unconsumed word is overwritten
module uart_rx #(
  parameter int DBIT = 8,
  parameter bit PARITY_EN = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int OS = 16
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            frame_err,
  output logic            parity_err,
  output logic            overrun
);
  localparam int SW = $clog2(OS);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic rx_meta, rxs, armed, done, perr, ferr;
  logic [SW-1:0] s;
  logic [2:0] n;
  logic [DBIT-1:0] sh;
  logic mid, last;
  assign mid = s_tick && s == SW'(OS/2-1);
  assign last = s_tick && s == SW'(OS-1);
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) {rx_meta, rxs} <= 2'b11;
    else {rx_meta, rxs} <= {rx, rx_meta};
  // armed requires the line to be seen high before a start edge, so a held-low break is reported once
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state <= IDLE;
      s <= '0;
      n <= '0;
      sh <= '0;
      armed <= 1'b0;
      done <= 1'b0;
      perr <= 1'b0;
      ferr <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (rxs) armed <= 1'b1;
          else if (armed) begin
            state <= START;
            s <= '0;
            armed <= 1'b0;
          end
        START:
          if (mid) begin
            state <= rxs ? IDLE : DATA;
            s <= '0;
            n <= '0;
          end else if (s_tick) s <= s + 1'b1;
        DATA:
          if (last) begin
            s <= '0;
            sh <= {rxs, sh[DBIT-1:1]};
            if (n == 3'(DBIT-1)) state <= PARITY_EN ? PARITY : STOP;
            else n <= n + 3'd1;
          end else if (s_tick) s <= s + 1'b1;
        PARITY:
          if (last) begin
            s <= '0;
            perr <= ^sh ^ rxs ^ PARITY_ODD;
            state <= STOP;
          end else if (s_tick) s <= s + 1'b1;
        STOP:
          if (last) begin
            s <= '0;
            ferr <= ~rxs;
            done <= 1'b1;
            armed <= 1'b0;
            state <= IDLE;
          end else if (s_tick) s <= s + 1'b1;
        default: state <= IDLE;
      endcase
    end
  // a commit wins over a same-cycle consume, so the new word stays valid
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      parity_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= done & rx_valid & ~rx_ready;
      if (done) begin
        rx_data <= sh;
        frame_err <= ferr;
        parity_err <= perr;
        rx_valid <= 1'b1;
      end else if (rx_ready) rx_valid <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx with a frame-level reference model
module tb_uart_rx;
  localparam int NI = 3;
  localparam int DB [NI] = '{8, 8, 6};
  localparam bit PE [NI] = '{1'b0, 1'b1, 1'b1};
  localparam bit PO [NI] = '{1'b0, 1'b0, 1'b1};
  localparam int BIT = 64;
  logic clk = 1'b0, arst_n = 1'b0, s_tick = 1'b0;
  logic [NI-1:0] rx = '1, rdy = '0, rdy_seen = '0;
  wire [7:0] d [NI];
  wire [NI-1:0] v, fe, pe, ov;
  int cyc = 0, vec = 0, err = 0, mode = 0, ov_cnt = 0;
  bit abort = 1'b0;
  bit ev [NI], efe [NI], epe [NI], eov [NI], pend [NI], pfe [NI], ppe [NI];
  logic [7:0] ed [NI], pd [NI];
  int pc [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_rx #(.DBIT(DB[g]), .PARITY_EN(PE[g]), .PARITY_ODD(PO[g]), .OS(16)) u (
      .clk(clk), .arst_n(arst_n), .s_tick(s_tick), .rx(rx[g]),
      .rx_data(d[g][DB[g]-1:0]), .rx_valid(v[g]), .rx_ready(rdy[g]),
      .frame_err(fe[g]), .parity_err(pe[g]), .overrun(ov[g]));
    if (DB[g] < 8) begin : g_pad
      assign d[g][7:DB[g]] = '0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rdy_seen <= rdy;

  initial forever begin
    @(posedge clk);
    #1 s_tick = ((cyc + 1) % 4 == 0);
  end

  // mode 0: low, 1: random, 2: only on the edge a word commits, 3: high
  initial forever begin
    @(posedge clk);
    #2;
    for (int g = 0; g < NI; g++)
      rdy[g] = (mode == 1) ? ($urandom_range(0, 3) == 0) :
               (mode == 2) ? (pend[g] && pc[g] == cyc + 1) : (mode == 3);
  end

  task automatic chk(string nm, int g, logic [7:0] act, logic [7:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s[%0d] cyc=%0d got=%h expected=%h", nm, g, cyc, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      if (!arst_n) begin
        ev[g] = 0; ed[g] = '0; efe[g] = 0; epe[g] = 0; eov[g] = 0; pend[g] = 0;
      end else begin
        eov[g] = 0;
        if (pend[g] && pc[g] == cyc) begin
          eov[g] = ev[g] && !rdy_seen[g];
          ev[g] = 1; ed[g] = pd[g]; efe[g] = pfe[g]; epe[g] = ppe[g]; pend[g] = 0;
        end else if (rdy_seen[g]) ev[g] = 0;
      end
      chk("rx_valid", g, 8'(v[g]), 8'(ev[g]));
      chk("rx_data", g, d[g], ed[g]);
      chk("frame_err", g, 8'(fe[g]), 8'(efe[g]));
      chk("parity_err", g, 8'(pe[g]), 8'(epe[g]));
      chk("overrun", g, 8'(ov[g]), 8'(eov[g]));
    end
    if (ov[0]) ov_cnt++;
  end

  task automatic wait_cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // the word is judged at tick OS/2 of the start bit and every OS ticks after; commit is one clock later
  task automatic expect_frame(int g, int f, logic [7:0] dm, bit ferr, bit perr);
    int t1;
    t1 = ((f + 6) / 4) * 4;
    pc[g] = t1 + 29 + BIT * (DB[g] + int'(PE[g]) + 1);
    pd[g] = dm; pfe[g] = ferr; ppe[g] = perr; pend[g] = 1;
  endtask

  task automatic send_frame(int g, logic [7:0] data, bit par, bit stp);
    logic [7:0] dm;
    logic [11:0] b;
    int nb;
    dm = data & 8'((1 << DB[g]) - 1);
    nb = DB[g] + int'(PE[g]) + 2;
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < DB[g]; i++) b[i+1] = dm[i];
    if (PE[g]) b[DB[g]+1] = par;
    b[nb-1] = stp;
    @(posedge clk);
    #1;
    expect_frame(g, cyc + 1, dm, !stp,
                 PE[g] && ((($countones(dm) + int'(par)) % 2) != int'(PO[g])));
    for (int i = 0; i < nb; i++) begin
      if (abort) break;
      rx[g] = b[i];
      for (int k = 0; k < BIT && !abort; k++) @(posedge clk);
      #1;
    end
    rx[g] = 1'b1;
  endtask

  task automatic send_break(int g, int len);
    @(posedge clk);
    #1;
    expect_frame(g, cyc + 1, 8'h00, 1'b1, PE[g] && PO[g]);
    rx[g] = 1'b0;
    wait_cyc(len);
    rx[g] = 1'b1;
  endtask

  task automatic pulse_ready;
    @(posedge clk);
    #1 mode = 3;
    @(posedge clk);
    #1 mode = 0;
  endtask

  task automatic rand_run(int g);
    for (int i = 0; i < 12; i++) begin
      logic [7:0] dt;
      bit par, stp;
      dt = 8'($urandom);
      par = 1'($urandom);
      stp = ($urandom_range(0, 4) != 0);
      send_frame(g, dt, par, stp);
      if (!stp || $urandom_range(0, 1) == 1) repeat ($urandom_range(8, 80)) @(posedge clk);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1);
  end

  initial begin
    wait_cyc(3);
    chk("rst_valid", 0, 8'(v[0]), 8'h00);
    chk("rst_data", 0, d[0], 8'h00);
    chk("rst_overrun", 0, 8'(ov[0]), 8'h00);
    arst_n = 1'b1;
    wait_cyc(20);
    send_frame(0, 8'hA5, 1'b0, 1'b1);
    wait_cyc(40);
    chk("clean_data", 0, d[0], 8'hA5);
    chk("clean_valid", 0, 8'(v[0]), 8'h01);
    chk("clean_ferr", 0, 8'(fe[0]), 8'h00);
    chk("clean_perr", 0, 8'(pe[0]), 8'h00);
    wait_cyc(30);
    chk("hold_valid", 0, 8'(v[0]), 8'h01);
    pulse_ready;
    wait_cyc(3);
    chk("consumed_valid", 0, 8'(v[0]), 8'h00);
    chk("consumed_data", 0, d[0], 8'hA5);
    @(posedge clk);
    #1 rx[0] = 1'b0;
    wait_cyc(20);
    rx[0] = 1'b1;
    wait_cyc(150);
    chk("glitch_valid", 0, 8'(v[0]), 8'h00);
    chk("glitch_ferr", 0, 8'(fe[0]), 8'h00);
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    wait_cyc(40);
    chk("ferr_data", 0, d[0], 8'h3C);
    chk("ferr_flag", 0, 8'(fe[0]), 8'h01);
    pulse_ready;
    send_break(0, 3 * 10 * BIT);
    wait_cyc(100);
    chk("break_data", 0, d[0], 8'h00);
    chk("break_ferr", 0, 8'(fe[0]), 8'h01);
    pulse_ready;
    send_frame(0, 8'h5A, 1'b0, 1'b1);
    wait_cyc(40);
    chk("after_break", 0, d[0], 8'h5A);
    pulse_ready;
    send_frame(1, 8'h07, 1'b1, 1'b1);
    wait_cyc(40);
    chk("even_ok", 1, 8'(pe[1]), 8'h00);
    chk("even_data", 1, d[1], 8'h07);
    pulse_ready;
    send_frame(1, 8'h07, 1'b0, 1'b1);
    wait_cyc(40);
    chk("even_bad", 1, 8'(pe[1]), 8'h01);
    pulse_ready;
    send_frame(2, 8'h07, 1'b0, 1'b1);
    wait_cyc(40);
    chk("odd_ok", 2, 8'(pe[2]), 8'h00);
    chk("odd_data", 2, d[2], 8'h07);
    pulse_ready;
    ov_cnt = 0;
    send_frame(0, 8'h11, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b1);
    wait_cyc(40);
    chk("ovr_data", 0, d[0], 8'h22);
    chk("ovr_valid", 0, 8'(v[0]), 8'h01);
    chk("ovr_pulses", 0, 8'(ov_cnt), 8'h01);
    mode = 2;
    ov_cnt = 0;
    send_frame(0, 8'h33, 1'b0, 1'b1);
    send_frame(0, 8'h44, 1'b0, 1'b1);
    wait_cyc(40);
    mode = 0;
    chk("noovr_pulses", 0, 8'(ov_cnt), 8'h00);
    chk("noovr_data", 0, d[0], 8'h44);
    chk("noovr_valid", 0, 8'(v[0]), 8'h01);
    fork
      send_frame(0, 8'h55, 1'b0, 1'b1);
      begin
        wait_cyc(250);
        #2;
        arst_n = 1'b0;
        abort = 1'b1;
        rx = '1;
      end
    join
    wait_cyc(3);
    chk("midrst_valid", 0, 8'(v[0]), 8'h00);
    chk("midrst_data", 0, d[0], 8'h00);
    abort = 1'b0;
    arst_n = 1'b1;
    wait_cyc(50);
    send_frame(0, 8'h96, 1'b0, 1'b1);
    wait_cyc(40);
    chk("post_rst_data", 0, d[0], 8'h96);
    chk("post_rst_valid", 0, 8'(v[0]), 8'h01);
    mode = 1;
    fork
      rand_run(0);
      rand_run(1);
      rand_run(2);
    join
    mode = 0;
    wait_cyc(20);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
